// File: rtl/dma_rsp_enc.sv
// dma_rsp_enc: rebuilds virtual read-response addresses from physical tags and
// queues them in order toward the AXI bridge.
package dma_rsp_enc_pkg;
    localparam int CH_ADDR_WIDTH  = 3;
    localparam int BK_ADDR_WIDTH  = 4;
    localparam int ROW_ADDR_WIDTH = 14;
    localparam int COL_ADDR_WIDTH = 6;
    localparam int GPR_ADDR_WIDTH = 5;
    localparam int CFR_ADDR_WIDTH = 5;
    localparam int DATA_WIDTH     = 32;
    localparam logic [31:0] GPR_ADDR_0 = 32'hF000_0000;
    localparam logic [31:0] CFR_ADDR_0 = 32'hF000_1000;
    localparam logic [31:0] ISR_ADDR_0 = 32'hF000_2000;
    typedef enum logic [2:0] {
        RoChBaCo = 3'd0,
        RoCoBaCh = 3'd1,
        ChRoBaCo = 3'd2,
        ChRoCoBa = 3'd3
    } addr_map_t;
    typedef enum logic [1:0] {
        DRAM_RANGE = 2'd0,
        GPR_RANGE  = 2'd1,
        CFR_RANGE  = 2'd2,
        ISR_RANGE  = 2'd3
    } addr_range_t;
endpackage

module dma_rsp_enc
    import dma_rsp_enc_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  addr_map_t                   ADDR_MAP,
    input  logic                        dcore_rsp_valid,
    output logic                        renc_rdy,
    input  addr_range_t                 dcore_rsp_range,
    input  logic [CH_ADDR_WIDTH-1:0]    dcore_rsp_ch_addr,
    input  logic [BK_ADDR_WIDTH-1:0]    dcore_rsp_bk_addr,
    input  logic [ROW_ADDR_WIDTH-1:0]   dcore_rsp_row_addr,
    input  logic [COL_ADDR_WIDTH-1:0]   dcore_rsp_col_addr,
    input  logic [GPR_ADDR_WIDTH-1:0]   dcore_rsp_gpr_addr,
    input  logic [CFR_ADDR_WIDTH-1:0]   dcore_rsp_cfr_addr,
    input  logic [DATA_WIDTH-1:0]       dcore_rsp_data,
    output logic                        renc_pkt_valid,
    input  logic                        axbr_rsp_rdy,
    output logic [ADDR_WIDTH-1:0]       renc_pkt_addr,
    output logic [DATA_WIDTH-1:0]       renc_pkt_data,
    output logic                        renc_pkt_err,
    output logic                        renc_err_sticky,
    output logic [$clog2(DEPTH):0]      renc_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int C  = CH_ADDR_WIDTH;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  err;
    } entry_t;

    entry_t                mem [DEPTH];
    entry_t                wr_entry;
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [ADDR_WIDTH-1:0] dram_addr;
    logic                  push, pop, is_isr;

    assign renc_rdy       = renc_count != CW'(DEPTH);
    assign renc_pkt_valid = renc_count != '0;
    assign push           = dcore_rsp_valid && renc_rdy;
    assign pop            = renc_pkt_valid && axbr_rsp_rdy;
    assign is_isr         = dcore_rsp_range == ISR_RANGE;

    always_comb begin
        dram_addr = '0;
        case (ADDR_MAP)
            RoChBaCo: begin
                dram_addr[15+C+:ROW_ADDR_WIDTH] = dcore_rsp_row_addr;
                dram_addr[15+:C]                = dcore_rsp_ch_addr;
                dram_addr[11+:BK_ADDR_WIDTH]    = dcore_rsp_bk_addr;
                dram_addr[5+:COL_ADDR_WIDTH]    = dcore_rsp_col_addr;
            end
            RoCoBaCh: begin
                dram_addr[15+C+:ROW_ADDR_WIDTH] = dcore_rsp_row_addr;
                dram_addr[9+C+:COL_ADDR_WIDTH]  = dcore_rsp_col_addr;
                dram_addr[5+C+:BK_ADDR_WIDTH]   = dcore_rsp_bk_addr;
                dram_addr[5+:C]                 = dcore_rsp_ch_addr;
            end
            ChRoBaCo: begin
                dram_addr[29+:C]                = dcore_rsp_ch_addr;
                dram_addr[15+:ROW_ADDR_WIDTH]   = dcore_rsp_row_addr;
                dram_addr[11+:BK_ADDR_WIDTH]    = dcore_rsp_bk_addr;
                dram_addr[5+:COL_ADDR_WIDTH]    = dcore_rsp_col_addr;
            end
            ChRoCoBa: begin
                dram_addr[29+:C]                = dcore_rsp_ch_addr;
                dram_addr[15+:ROW_ADDR_WIDTH]   = dcore_rsp_row_addr;
                dram_addr[9+:COL_ADDR_WIDTH]    = dcore_rsp_col_addr;
                dram_addr[5+:BK_ADDR_WIDTH]     = dcore_rsp_bk_addr;
            end
            default: dram_addr = '0;
        endcase
    end

    always_comb begin
        wr_entry.addr = dcore_rsp_range == GPR_RANGE ? ADDR_WIDTH'(GPR_ADDR_0) + (ADDR_WIDTH'(dcore_rsp_gpr_addr) << 5) :
                        dcore_rsp_range == CFR_RANGE ? ADDR_WIDTH'(CFR_ADDR_0) + (ADDR_WIDTH'(dcore_rsp_cfr_addr) << 5) :
                        is_isr                       ? ADDR_WIDTH'(ISR_ADDR_0) : dram_addr;
        wr_entry.data = is_isr ? '0 : dcore_rsp_data;
        wr_entry.err  = is_isr;
    end

    // Payload storage is left unreset; outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            renc_count      <= '0;
            renc_err_sticky <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            renc_count <= renc_count + CW'(push) - CW'(pop);
            if (push && is_isr) renc_err_sticky <= 1'b1;
        end
    end

    assign renc_pkt_addr = renc_pkt_valid ? mem[rd_ptr].addr : '0;
    assign renc_pkt_data = renc_pkt_valid ? mem[rd_ptr].data : '0;
    assign renc_pkt_err  = renc_pkt_valid && mem[rd_ptr].err;
endmodule

// File: tb/tb_dma_rsp_enc.sv
// tb_dma_rsp_enc: directed vectors with hand-computed addresses for dma_rsp_enc.
module tb_dma_rsp_enc;
    import dma_rsp_enc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    addr_map_t   addr_map = RoChBaCo;
    logic        dcore_rsp_valid = 1'b0;
    logic        renc_rdy;
    addr_range_t dcore_rsp_range = DRAM_RANGE;
    logic [2:0]  ch = '0;
    logic [3:0]  bk = '0;
    logic [13:0] row = '0;
    logic [5:0]  col = '0;
    logic [4:0]  gpr = '0;
    logic [4:0]  cfr = '0;
    logic [31:0] wdata = '0;
    logic        renc_pkt_valid;
    logic        axbr_rsp_rdy = 1'b0;
    logic [31:0] renc_pkt_addr;
    logic [31:0] renc_pkt_data;
    logic        renc_pkt_err;
    logic        renc_err_sticky;
    logic [2:0]  renc_count;
    int          n_chk = 0;
    int          n_pass = 0;

    dma_rsp_enc #(.DEPTH(4), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .ADDR_MAP(addr_map),
        .dcore_rsp_valid(dcore_rsp_valid), .renc_rdy(renc_rdy),
        .dcore_rsp_range(dcore_rsp_range), .dcore_rsp_ch_addr(ch),
        .dcore_rsp_bk_addr(bk), .dcore_rsp_row_addr(row), .dcore_rsp_col_addr(col),
        .dcore_rsp_gpr_addr(gpr), .dcore_rsp_cfr_addr(cfr), .dcore_rsp_data(wdata),
        .renc_pkt_valid(renc_pkt_valid), .axbr_rsp_rdy(axbr_rsp_rdy),
        .renc_pkt_addr(renc_pkt_addr), .renc_pkt_data(renc_pkt_data),
        .renc_pkt_err(renc_pkt_err), .renc_err_sticky(renc_err_sticky),
        .renc_count(renc_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_dram(input addr_map_t m, input logic [2:0] c, input logic [3:0] b,
                              input logic [13:0] r, input logic [5:0] co, input logic [31:0] d);
        dcore_rsp_valid = 1'b1;
        dcore_rsp_range = DRAM_RANGE;
        addr_map = m; ch = c; bk = b; row = r; col = co; wdata = d;
    endtask

    task automatic drive_gpr(input logic [4:0] g, input logic [31:0] d);
        dcore_rsp_valid = 1'b1;
        dcore_rsp_range = GPR_RANGE;
        gpr = g; wdata = d;
    endtask

    task automatic check_head(input string tag, input logic [31:0] a, input logic [31:0] d, input logic e);
        check({tag, "_valid"}, 64'(renc_pkt_valid), 64'd1);
        check({tag, "_addr"}, 64'(renc_pkt_addr), 64'(a));
        check({tag, "_data"}, 64'(renc_pkt_data), 64'(d));
        check({tag, "_err"}, 64'(renc_pkt_err), 64'(e));
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] exp_a;
    int          pushed;

    initial begin
        #2;
        check("rst_valid", 64'(renc_pkt_valid), 64'd0);
        check("rst_count", 64'(renc_count), 64'd0);
        check("rst_sticky", 64'(renc_err_sticky), 64'd0);
        check("rst_addr", 64'(renc_pkt_addr), 64'd0);
        step();
        rst = 1'b0;
        step();
        check("rst_rdy", 64'(renc_rdy), 64'd1);

        // single DRAM beat, RoChBaCo
        axbr_rsp_rdy = 1'b1;
        drive_dram(RoChBaCo, 3'd2, 4'd3, 14'd5, 6'h11, 32'hD0D0_0001);
        step();
        dcore_rsp_valid = 1'b0;
        addr_map = ChRoBaCo;
        check_head("rochbaco", 32'h0015_1A20, 32'hD0D0_0001, 1'b0);
        check("rochbaco_cnt", 64'(renc_count), 64'd1);
        step();
        check("rochbaco_drain", 64'(renc_count), 64'd0);
        check("rochbaco_vld0", 64'(renc_pkt_valid), 64'd0);

        // mixed ranges queued, ADDR_MAP changed after queueing
        axbr_rsp_rdy = 1'b0;
        drive_dram(ChRoCoBa, 3'd1, 4'd4, 14'd2, 6'd3, 32'h1111_1111);
        step();
        drive_gpr(5'd3, 32'h2222_2222);
        step();
        dcore_rsp_range = CFR_RANGE; cfr = 5'd1; wdata = 32'h3333_3333;
        step();
        drive_dram(ChRoBaCo, 3'd7, 4'hF, 14'h3FFF, 6'h3F, 32'h4444_4444);
        step();
        dcore_rsp_valid = 1'b0;
        addr_map = RoChBaCo;
        check("mix_cnt", 64'(renc_count), 64'd4);
        check("mix_rdy", 64'(renc_rdy), 64'd0);
        axbr_rsp_rdy = 1'b1;
        check_head("chrocoba", 32'h2001_0680, 32'h1111_1111, 1'b0);
        step();
        check_head("gpr", 32'hF000_0060, 32'h2222_2222, 1'b0);
        step();
        check_head("cfr", 32'hF000_1020, 32'h3333_3333, 1'b0);
        step();
        check_head("chrobaco_max", 32'hFFFF_FFE0, 32'h4444_4444, 1'b0);
        step();
        check("mix_empty", 64'(renc_count), 64'd0);

        // overflow hold-off: 5 pushes into DEPTH=4
        axbr_rsp_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_gpr(5'(i), 32'(i));
            step();
        end
        drive_gpr(5'd4, 32'd4);
        check("full_cnt", 64'(renc_count), 64'd4);
        check("full_rdy", 64'(renc_rdy), 64'd0);
        step();
        check("held_cnt", 64'(renc_count), 64'd4);
        check_head("held_head", 32'hF000_0000, 32'd0, 1'b0);
        axbr_rsp_rdy = 1'b1;
        step();
        check("pop1_cnt", 64'(renc_count), 64'd3);
        check("pop1_rdy", 64'(renc_rdy), 64'd1);
        step();
        dcore_rsp_valid = 1'b0;
        check("push5_cnt", 64'(renc_count), 64'd3);
        for (int i = 2; i < 5; i++) begin
            check_head("ovf_order", 32'hF000_0000 + 32'(i * 32), 32'(i), 1'b0);
            step();
        end
        check("ovf_empty", 64'(renc_count), 64'd0);

        // full FIFO with toggling ready and continuous valid: scoreboard check
        axbr_rsp_rdy = 1'b0;
        pushed = 0;
        for (int cyc = 0; cyc < 200 && (pushed < 16 || exp_q.size() != 0); cyc++) begin
            dcore_rsp_valid = pushed < 16;
            gpr = 5'(pushed);
            wdata = 32'hA500_0000 + 32'(pushed);
            dcore_rsp_range = GPR_RANGE;
            if (pushed >= 4) axbr_rsp_rdy = ~axbr_rsp_rdy;
            check("tog_cnt", 64'(renc_count), 64'(exp_q.size()));
            check("tog_rdy", 64'(renc_rdy), 64'(exp_q.size() != 4));
            if (exp_q.size() != 0 && axbr_rsp_rdy) begin
                exp_a = exp_q.pop_front();
                check("tog_addr", 64'(renc_pkt_addr), 64'(exp_a));
                check("tog_data", 64'(renc_pkt_data), 64'(32'hA500_0000 + ((exp_a - 32'hF000_0000) >> 5)));
            end
            if (dcore_rsp_valid && exp_q.size() + (axbr_rsp_rdy && renc_pkt_valid ? 1 : 0) < 4 + 0) begin
                exp_q.push_back(32'hF000_0000 + 32'(pushed * 32));
                pushed++;
            end
            step();
        end
        dcore_rsp_valid = 1'b0;
        check("tog_done", 64'(pushed), 64'd16);
        check("tog_empty", 64'(renc_count), 64'd0);

        // ISR range: data forced to 0, err and sticky set
        axbr_rsp_rdy = 1'b0;
        dcore_rsp_valid = 1'b1;
        dcore_rsp_range = ISR_RANGE;
        wdata = 32'hFFFF_FFFF;
        step();
        drive_dram(RoCoBaCh, 3'd4, 4'd3, 14'd1, 6'd2, 32'h5555_5555);
        step();
        dcore_rsp_valid = 1'b0;
        check_head("isr", 32'hF000_2000, 32'd0, 1'b1);
        check("isr_sticky", 64'(renc_err_sticky), 64'd1);
        axbr_rsp_rdy = 1'b1;
        step();
        check_head("rocobach", 32'h0004_2380, 32'h5555_5555, 1'b0);
        check("sticky_hold", 64'(renc_err_sticky), 64'd1);
        step();

        // unlisted map gives address 0
        drive_dram(addr_map_t'(3'd4), 3'd7, 4'hF, 14'h3FFF, 6'h3F, 32'h6666_6666);
        step();
        dcore_rsp_valid = 1'b0;
        check_head("badmap", 32'd0, 32'h6666_6666, 1'b0);
        step();

        // async reset with two entries queued
        axbr_rsp_rdy = 1'b0;
        drive_gpr(5'd7, 32'h7);
        step();
        drive_gpr(5'd8, 32'h8);
        step();
        dcore_rsp_valid = 1'b0;
        check("prerst_cnt", 64'(renc_count), 64'd2);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(renc_pkt_valid), 64'd0);
        check("arst_cnt", 64'(renc_count), 64'd0);
        check("arst_sticky", 64'(renc_err_sticky), 64'd0);
        step();
        rst = 1'b0;
        check("postrst_rdy", 64'(renc_rdy), 64'd1);
        drive_dram(RoChBaCo, 3'd2, 4'd3, 14'd5, 6'h11, 32'hBEEF_0000);
        step();
        dcore_rsp_valid = 1'b0;
        check_head("postrst", 32'h0015_1A20, 32'hBEEF_0000, 1'b0);
        check("postrst_cnt", 64'(renc_count), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
